// File: rtl/requant_u8_pipe.sv
// Five-stage requantizer: signed ACC_W accumulators -> unsigned OUT_W activations
// using per-channel {m0, shift} tables, weight zero-point correction and valid/ready flow control.
module requant_u8_pipe #(
    parameter int ACC_W = 32,
    parameter int ZW_W  = 16,
    parameter int OUT_W = 8,
    parameter int CH    = 8,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [CW-1:0]           cfg_addr,
    input  logic signed [ACC_W-1:0] cfg_m0,
    input  logic [4:0]              cfg_shift,
    input  logic signed [ZW_W-1:0]  z_of_weight,
    input  logic [OUT_W-1:0]        z3,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [ACC_W-1:0] act_sum_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [CW-1:0]           out_ch
);

    localparam int PW   = 2 * ACC_W;
    localparam int AZ_W = ACC_W + ZW_W;

    localparam logic signed [ACC_W-1:0] INT_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] INT_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [CW-1:0]           CH_LAST   = CW'(CH - 1);
    localparam logic [CW:0]             CH_LIM    = (CW + 1)'(CH);
    localparam logic signed [PW-1:0]    NUDGE_POS = {{(ACC_W+1){1'b0}}, 1'b1, {(ACC_W-2){1'b0}}};
    localparam logic signed [PW-1:0]    NUDGE_NEG = {{(ACC_W+2){1'b1}}, {(ACC_W-3){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0]    DIV_BIAS  = {{(ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};

    logic signed [ACC_W-1:0] tbl_m0_r [CH];
    logic [4:0]              tbl_sh_r [CH];
    logic [CW-1:0]           ch_cnt_r;

    logic                    adv_s;
    logic                    accept_s;
    logic                    addr_ok_s;
    logic [CW-1:0]           ch_sel_s;
    logic [CW-1:0]           ch_next_s;
    logic signed [ACC_W-1:0] prod_s;

    logic                    s1_v_r, s2_v_r, s3_v_r, s4_v_r;
    logic signed [ACC_W-1:0] s1_acc_r, s1_prod_r, s1_m0_r;
    logic [4:0]              s1_sh_r;
    logic [CW-1:0]           s1_ch_r;
    logic signed [ACC_W-1:0] s2_x_r, s2_m0_r;
    logic [4:0]              s2_sh_r;
    logic [CW-1:0]           s2_ch_r;
    logic signed [PW-1:0]    s3_p_r;
    logic                    s3_sat_r;
    logic [4:0]              s3_sh_r;
    logic [CW-1:0]           s3_ch_r;
    logic signed [ACC_W-1:0] s4_h_r;
    logic [4:0]              s4_sh_r;
    logic [CW-1:0]           s4_ch_r;

    logic signed [PW-1:0]    sum_s;
    logic signed [PW-1:0]    biased_s;
    logic signed [ACC_W-1:0] h_s;
    logic [ACC_W-1:0]        mask_s;
    logic [ACC_W-1:0]        rem_s;
    logic [ACC_W-1:0]        thr_s;
    logic                    rnd_s;
    logic signed [ACC_W-1:0] h_sh_s;
    logic signed [ACC_W-1:0] r_s;
    logic [ACC_W:0]          y_s;
    logic [OUT_W-1:0]        y_clamp_s;

    // Flow control, channel selection and the S1 zero-point product.
    always_comb begin
        adv_s     = ~out_valid | out_ready;
        in_ready  = adv_s;
        accept_s  = in_valid & adv_s;
        addr_ok_s = ({1'b0, cfg_addr} < CH_LIM);
        ch_sel_s  = in_first ? {CW{1'b0}} : ch_cnt_r;
        ch_next_s = (ch_sel_s == CH_LAST) ? {CW{1'b0}} : ch_sel_s + CW'(1'b1);
        prod_s    = ACC_W'(AZ_W'(act_sum_in) * AZ_W'(z_of_weight));
    end

    // Parameter table; a same-cycle write is seen only by later beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                tbl_m0_r[i] <= {ACC_W{1'b0}};
                tbl_sh_r[i] <= 5'd0;
            end
        end else if (cfg_we && addr_ok_s) begin
            tbl_m0_r[cfg_addr] <= cfg_m0;
            tbl_sh_r[cfg_addr] <= cfg_shift;
        end
    end

    // Channel counter and stage valid chain; everything holds while adv_s is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_cnt_r  <= {CW{1'b0}};
            s1_v_r    <= 1'b0;
            s2_v_r    <= 1'b0;
            s3_v_r    <= 1'b0;
            s4_v_r    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv_s) begin
            if (accept_s) begin
                ch_cnt_r <= ch_next_s;
            end
            s1_v_r    <= in_valid;
            s2_v_r    <= s1_v_r;
            s3_v_r    <= s2_v_r;
            s4_v_r    <= s3_v_r;
            out_valid <= s4_v_r;
        end
    end

    // S1/S2 data: capture operands and table entry, then form x = acc - prod.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_acc_r  <= {ACC_W{1'b0}};
            s1_prod_r <= {ACC_W{1'b0}};
            s1_m0_r   <= {ACC_W{1'b0}};
            s1_sh_r   <= 5'd0;
            s1_ch_r   <= {CW{1'b0}};
            s2_x_r    <= {ACC_W{1'b0}};
            s2_m0_r   <= {ACC_W{1'b0}};
            s2_sh_r   <= 5'd0;
            s2_ch_r   <= {CW{1'b0}};
        end else if (adv_s) begin
            if (in_valid) begin
                s1_acc_r  <= acc_in;
                s1_prod_r <= prod_s;
                s1_m0_r   <= tbl_m0_r[ch_sel_s];
                s1_sh_r   <= tbl_sh_r[ch_sel_s];
                s1_ch_r   <= ch_sel_s;
            end
            if (s1_v_r) begin
                s2_x_r  <= s1_acc_r - s1_prod_r;
                s2_m0_r <= s1_m0_r;
                s2_sh_r <= s1_sh_r;
                s2_ch_r <= s1_ch_r;
            end
        end
    end

    // S3/S4 data: full-width product with INT_MIN*INT_MIN flag, then the rounded high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_p_r   <= {PW{1'b0}};
            s3_sat_r <= 1'b0;
            s3_sh_r  <= 5'd0;
            s3_ch_r  <= {CW{1'b0}};
            s4_h_r   <= {ACC_W{1'b0}};
            s4_sh_r  <= 5'd0;
            s4_ch_r  <= {CW{1'b0}};
        end else if (adv_s) begin
            if (s2_v_r) begin
                s3_p_r   <= PW'(s2_x_r) * PW'(s2_m0_r);
                s3_sat_r <= (s2_x_r == INT_MIN) && (s2_m0_r == INT_MIN);
                s3_sh_r  <= s2_sh_r;
                s3_ch_r  <= s2_ch_r;
            end
            if (s3_v_r) begin
                s4_h_r  <= h_s;
                s4_sh_r <= s3_sh_r;
                s4_ch_r <= s3_ch_r;
            end
        end
    end

    // S4 combinational: nudge then divide by 2^(ACC_W-1) truncating toward zero.
    always_comb begin
        sum_s    = s3_p_r + (s3_p_r[PW-1] ? NUDGE_NEG : NUDGE_POS);
        biased_s = sum_s;
        if (sum_s[PW-1]) begin
            biased_s = sum_s + DIV_BIAS;
        end else begin
            biased_s = sum_s;
        end
        h_s = s3_sat_r ? INT_MAX : ACC_W'(biased_s >>> (ACC_W - 1));
    end

    // S5 combinational: rounding right shift (ties away from zero), zero point, clamp.
    always_comb begin
        mask_s    = ~({ACC_W{1'b1}} << s4_sh_r);
        rem_s     = s4_h_r & mask_s;
        thr_s     = (mask_s >> 1'b1) + {{(ACC_W-1){1'b0}}, s4_h_r[ACC_W-1]};
        rnd_s     = (rem_s > thr_s);
        h_sh_s    = s4_h_r >>> s4_sh_r;
        r_s       = h_sh_s + {{(ACC_W-1){1'b0}}, rnd_s};
        y_s       = {r_s[ACC_W-1], r_s} + {{(ACC_W+1-OUT_W){1'b0}}, z3};
        y_clamp_s = y_s[OUT_W-1:0];
        if (y_s[ACC_W]) begin
            y_clamp_s = {OUT_W{1'b0}};
        end else if (|y_s[ACC_W-1:OUT_W]) begin
            y_clamp_s = {OUT_W{1'b1}};
        end else begin
            y_clamp_s = y_s[OUT_W-1:0];
        end
    end

    // Output register: result and channel stay put while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= {OUT_W{1'b0}};
            out_ch   <= {CW{1'b0}};
        end else if (adv_s && s4_v_r) begin
            out_data <= y_clamp_s;
            out_ch   <= s4_ch_r;
        end
    end

endmodule

// File: tb/tb_requant_u8_pipe.sv
// Directed plus randomized bench for requant_u8_pipe (CH=4) against an arithmetic reference model.
module tb_requant_u8_pipe;

    localparam int CH = 4;
    localparam int INT_MIN_I = 32'sh8000_0000;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_m0;
    logic [4:0]  cfg_shift;
    logic [15:0] z_of_weight;
    logic [7:0]  z3;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic [31:0] acc_in;
    logic [31:0] act_sum_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    requant_u8_pipe #(.ACC_W(32), .ZW_W(16), .OUT_W(8), .CH(CH)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_m0(cfg_m0), .cfg_shift(cfg_shift),
        .z_of_weight(z_of_weight), .z3(z3),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .acc_in(acc_in), .act_sum_in(act_sum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
        int         lit;
        int         lit_ch;
    } exp_t;

    exp_t        exp_q[$];
    int          mdl_m0 [CH];
    int          mdl_sh [CH];
    int          mdl_cnt;
    int          checks = 0;
    int          failures = 0;
    int          stall_cycles;
    int          pend_lit;
    int          pend_lit_ch;
    bit          acc_done;
    bit          prev_held;
    logic [7:0]  prev_data;
    logic [1:0]  prev_ch;
    int          lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Requantization from the arithmetic definition: rounded fixed-point scale,
    // round-half-away-from-zero divide by 2^sh, add zero point, clamp to 0..255.
    function automatic logic [7:0] ref_requant(input int acc, input int act, input int zw,
                                               input int m0, input int sh, input int zp);
        int prod, x;
        longint p, h, r, y, half, nud;
        prod = act * zw;
        x = acc - prod;
        if (x == INT_MIN_I && m0 == INT_MIN_I) begin
            h = 64'sd2147483647;
        end else begin
            p   = longint'(x) * longint'(m0);
            nud = (p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
            h   = (p + nud) / 64'sd2147483648;
        end
        half = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
        if (h >= 0) r = (h + half) >>> sh;
        else        r = -((-h + half) >>> sh);
        y = r + zp;
        if (y < 0)   return 8'd0;
        if (y > 255) return 8'd255;
        return 8'(y);
    endfunction

    task automatic tick();
        exp_t e;
        int   ch;
        out_ready = (stall_cycles == 0);
        if (stall_cycles > 0) stall_cycles--;
        #1;
        if (prev_held) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_ch", out_ch, prev_ch);
        end
        if (!out_ready) begin
            if (out_valid) chk("stall_in_ready", in_ready, 1'b0);
        end else begin
            chk("free_in_ready", in_ready, 1'b1);
        end
        prev_held = out_valid && !out_ready;
        prev_data = out_data;
        prev_ch   = out_ch;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_extra", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_ch", out_ch, e.ch);
                if (e.lit >= 0)    chk("out_data_lit", out_data, e.lit);
                if (e.lit_ch >= 0) chk("out_ch_lit", out_ch, e.lit_ch);
            end
        end
        acc_done = 1'b0;
        if (in_valid && in_ready) begin
            ch       = in_first ? 0 : mdl_cnt;
            e.d      = ref_requant(int'(acc_in), int'(act_sum_in), int'(shortint'(z_of_weight)),
                                   mdl_m0[ch], mdl_sh[ch], int'(z3));
            e.ch     = ch[1:0];
            e.lit    = pend_lit;
            e.lit_ch = pend_lit_ch;
            exp_q.push_back(e);
            mdl_cnt  = (ch + 1) % CH;
            acc_done = 1'b1;
        end
        if (cfg_we) begin
            mdl_m0[cfg_addr] = int'(cfg_m0);
            mdl_sh[cfg_addr] = int'(cfg_shift);
        end
        @(negedge clk);
    endtask

    task automatic beat(input bit first, input int acc, input int act, input int lit, input int lit_ch);
        int n;
        n = 0;
        in_valid    = 1'b1;
        in_first    = first;
        acc_in      = acc;
        act_sum_in  = act;
        pend_lit    = lit;
        pend_lit_ch = lit_ch;
        acc_done    = 1'b0;
        while (!acc_done && n < 50) begin
            tick();
            n++;
        end
        if (!acc_done) chk("accept_timeout", acc_done, 1'b1);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic cfg(input int addr, input int m0, input int sh);
        cfg_we    = 1'b1;
        cfg_addr  = addr[1:0];
        cfg_m0    = m0;
        cfg_shift = sh[4:0];
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid     = 1'b0;
        stall_cycles = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
        chk("idle_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_m0 = 32'd0; cfg_shift = 5'd0;
        z_of_weight = 16'd5; z3 = 8'd3; in_valid = 1'b0; in_first = 1'b0;
        acc_in = 32'd0; act_sum_in = 32'd0; out_ready = 1'b1;
        stall_cycles = 0; prev_held = 1'b0; mdl_cnt = 0; pend_lit = -1; pend_lit_ch = -1;
        for (int c = 0; c < CH; c++) begin
            mdl_m0[c] = 0;
            mdl_sh[c] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'd0);
        chk("rst_out_ch", out_ch, 2'd0);
        reset = 1'b0;
        tick();

        // Basic: 478 clamps to 255, first result exactly 5 edges after (and including) accept.
        cfg(0, 32'h4000_0000, 0);
        in_valid = 1'b1; in_first = 1'b1; acc_in = 32'd1000; act_sum_in = 32'd10;
        pend_lit = 255; pend_lit_ch = 0;
        tick();
        chk("basic_accepted", acc_done, 1'b1);
        in_valid = 1'b0; in_first = 1'b0;
        lat = 1;
        while (lat < 20) begin
            #1;
            if (out_valid) break;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 5);
        tick();
        beat(1'b1, 300, 10, 128, 0);
        drain();

        // Rounding with m0 ~ 1.0.
        z3 = 8'd0;
        cfg(0, 32'h7FFF_FFFF, 1);
        beat(1'b1, -3, 0, 0, 0);
        beat(1'b1, 5, 0, 3, 0);
        drain();
        z3 = 8'd10;
        beat(1'b1, -5, 0, 7, 0);
        drain();
        z3 = 8'd0;
        cfg(0, 32'h7FFF_FFFF, 2);
        beat(1'b1, 6, 0, 2, 0);

        // INT_MIN*INT_MIN saturation and negative clamp.
        cfg(0, 32'h8000_0000, 0);
        beat(1'b1, 32'h8000_0000, 0, 255, 0);
        cfg(0, 32'h4000_0000, 0);
        beat(1'b1, -100000, 0, 0, 0);
        beat(1'b1, -4, 0, 0, 0);
        drain();

        // Per-channel wrap, in_first restart, in_first coinciding with wrap.
        for (int c = 0; c < CH; c++) cfg(c, 32'h7FFF_FFFF, c);
        for (int i = 0; i < 9; i++) beat(i == 0, 100 + 7 * i, 0, -1, i % 4);
        beat(1'b1, 61, 0, -1, 0);
        beat(1'b0, 62, 0, -1, 1);
        beat(1'b0, 63, 0, -1, 2);
        beat(1'b1, 64, 0, -1, 0);
        beat(1'b0, 65, 0, -1, 1);
        beat(1'b0, 66, 0, -1, 2);
        beat(1'b0, 67, 0, -1, 3);
        beat(1'b1, 68, 0, -1, 0);
        beat(1'b0, 69, 0, -1, 1);
        drain();

        // Table write racing a channel-0 beat.
        cfg(0, 32'h4000_0000, 0);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_m0 = 32'h7FFF_FFFF; cfg_shift = 5'd0;
        beat(1'b1, 200, 0, 100, 0);
        cfg_we = 1'b0;
        beat(1'b1, 200, 0, 200, 0);
        drain();

        // Backpressure mid-stream.
        for (int i = 0; i < 10; i++) begin
            if (i == 6) stall_cycles = 4;
            beat(i == 0, 50 + 3 * i, 1, -1, i % 4);
        end
        drain();

        // Randomized: full-range parameters, then moderate ones that avoid constant clamping.
        for (int ph = 0; ph < 2; ph++) begin
            z3 = 8'($urandom_range(0, 255));
            z_of_weight = 16'($urandom);
            for (int c = 0; c < CH; c++) begin
                if (ph == 0) cfg(c, int'($urandom), int'($urandom_range(0, 31)));
                else         cfg(c, int'($urandom_range(32'h0800_0000, 32'h7FFF_FFFF)), int'($urandom_range(0, 8)));
            end
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 9) == 0) stall_cycles = int'($urandom_range(1, 4));
                if (ph == 0) beat($urandom_range(0, 7) == 0, int'($urandom), int'($urandom), -1, -1);
                else         beat($urandom_range(0, 7) == 0, int'($urandom_range(0, 4000)) - 2000,
                                  int'($urandom_range(0, 40)) - 20, -1, -1);
            end
            drain();
        end

        // Reset with three beats in flight.
        z3 = 8'd7;
        beat(1'b1, 500, 0, -1, -1);
        beat(1'b0, 600, 0, -1, -1);
        beat(1'b0, 700, 0, -1, -1);
        reset = 1'b1;
        exp_q.delete();
        prev_held = 1'b0;
        mdl_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            mdl_m0[c] = 0;
            mdl_sh[c] = 0;
        end
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_data", out_data, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) tick();
        chk("post_rst_out_valid", out_valid, 1'b0);
        beat(1'b0, 12345, 99, 7, 0);
        beat(1'b0, -9999, 3, 7, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/requant_u8_pipe.md
# requant_u8_pipe

Parametrised, pipelined requantizer converting signed ACC_W-bit MAC+bias accumulators into unsigned OUT_W-bit activations, with per-output-channel multiplier/shift tables, weight-zero-point correction and valid/ready backpressure. It sits between the accumulator readout (ru_get path) and the output-activation buffer. It is the multi-channel, fully rounding, flow-controlled successor to the single-scale requant stage.

## Interface
- ACC_W, 32: accumulator, act-sum and M0 width (signed)
- ZW_W, 16: weight zero-point width (signed)
- OUT_W, 8: output width (unsigned); clamp range 0..2^OUT_W-1
- CH, 8: channel count and param-table depth (>=2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  param-table write strobe
- cfg_addr  in  clog2(CH)  table entry
- cfg_m0  in  ACC_W  signed Q0.31 multiplier
- cfg_shift  in  5  right-shift exponent 0..31
- z_of_weight  in  ZW_W  weight zero point, quasi-static
- z3  in  OUT_W  output zero point, quasi-static
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat
- in_first  in  1  beat is channel 0, restarting the counter
- acc_in  in  ACC_W  signed accumulator
- act_sum_in  in  ACC_W  signed activation sum for this output
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  requantized value
- out_ch  out  clog2(CH)  channel index of out_data

## Operation
- Beat accepted when in_valid & in_ready. Channel = 0 if in_first, else ch_cnt. ch_cnt then becomes channel+1, wrapping CH-1 -> 0.
- Param table: CH entries of {m0, shift}, written on cfg_we. On reset every entry is m0=0, shift=0. A beat accepted in the same cycle as a write to its channel uses the old entry; later beats use the new one.
- Datapath per beat. All intermediate values wrap to ACC_W except where a wider width is stated.
  - S1: register acc, act_sum*z_of_weight (truncated to ACC_W), m0, shift and channel.
  - S2: x = acc − prod.
  - S3: p = x*m0, full 2*ACC_W-bit signed product. Flag sat = (x == INT_MIN && m0 == INT_MIN).
  - S4: h = sat ? INT_MAX : (p + nudge) / 2^(ACC_W−1), truncating toward zero. nudge = p>=0 ? 2^(ACC_W−2) : 1−2^(ACC_W−2).
  - S5: mask = 2^shift−1, rem = h & mask, thr = (mask>>1) + (h<0), r = (h>>>shift) + (rem>thr). Then y = r + z3, computed at ACC_W+1 bits. Clamp y to 0..2^OUT_W−1 and register it to out_data/out_ch.
- Flow control: the pipeline advances when adv = ~out_valid | out_ready. in_ready = adv. While adv=0 every stage holds, including its valid bit. No bubble is inserted at full throughput.
- z_of_weight and z3 are sampled at S1 and S5 respectively. They change only while the pipe is empty.

## Timing
- Latency: 5 cycles from the accept edge to out_valid, when there is no stall. Throughput is 1 beat/cycle.
- Reset values: in_ready=1 after reset, out_valid=0, out_data=0, out_ch=0, ch_cnt=0, all stage valids 0.
- Reset mid-operation: in-flight beats are discarded, the table is cleared, and ch_cnt returns to 0. The first beat after reset is channel 0.
- out_data and out_ch stay stable while out_valid=1 and out_ready=0.
- Simultaneous in_first and ch_cnt wrap: in_first wins, giving channel 0, then ch_cnt=1.

## Test plan
- Basic: ch0 m0=0x40000000, shift=0, zw=5, z3=3, acc=1000, act_sum=10 -> out_data=478 (clamped to 255 when OUT_W=8), out_ch=0, 5 cycles after accept. Repeat with z3=3 and acc=300, act_sum=10, zw=5: x=250, h=125 -> out_data=128.
- Rounding: set m0=0x7FFFFFFF and vary x (acc) with shift=1. x=−3 -> h=−3, r=−2, y=−2+z3 with z3=0 -> 0. x=5 -> r=3. x=−5, z3=10 -> r=−3 -> 7. x=6, shift=2 -> r=2.
- Saturation/INT_MIN: acc=0x80000000, act_sum=0, m0=0x80000000 -> h=0x7FFFFFFF -> 255. Large negative acc gives y<0 -> 0.
- Per-channel wrap: CH=4, distinct shift per channel, 9 back-to-back beats -> out_ch sequence 0,1,2,3,0,1,2,3,0 with each result using its own channel's params. in_first on beat 3 -> sequence restarts at 0.
- Backpressure: stream 10 beats and hold out_ready=0 for 4 cycles mid-stream -> no loss or duplication, in-order results, in_ready=0 during the stall, out_data held.
- Reset mid-stream and table write race: assert reset with 3 beats in flight -> no out_valid afterwards, table reads 0. Write ch0 in the same cycle a ch0 beat is accepted -> that beat uses the old m0, the next ch0 beat uses the new m0.
